// File: rtl/window_address_counter.sv
// Window address counter for the register-file convolution datapath.
// A fill phase produces DATANUM sequential write addresses, then a slide
// phase presents KSIZE read taps per window, advancing the window by STRIDE
// on each ReadEn until the last window has been consumed.
module window_address_counter #(
   parameter int ADDRESS = 4,
   parameter int DATANUM = 15,
   parameter int KSIZE   = 3,
   parameter int STRIDE  = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       Start,
   input  logic                       WrValid,
   input  logic                       ReadEn,
   output logic                       WriteEn,
   output logic [ADDRESS-1:0]         WriteReg,
   output logic [KSIZE*ADDRESS-1:0]   ReadRegs,
   output logic                       ReadValid,
   output logic [ADDRESS-1:0]         WinIndex,
   output logic                       Busy,
   output logic                       Done
);

   // Window geometry: number of full windows and base of the last one.
   // Trailing words that cannot complete a window are never read.
   localparam int NWIN     = (DATANUM - KSIZE) / STRIDE + 1;
   localparam int LASTBASE = (NWIN - 1) * STRIDE;

   localparam logic [ADDRESS-1:0] C_LAST_WR   = ADDRESS'(DATANUM - 1);
   localparam logic [ADDRESS-1:0] C_LAST_BASE = ADDRESS'(LASTBASE);
   localparam logic [ADDRESS-1:0] C_STRIDE    = ADDRESS'(STRIDE);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_SLIDE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]         r_state;
   logic [ADDRESS-1:0] r_write_reg;
   logic [ADDRESS-1:0] r_base;
   logic [ADDRESS-1:0] r_win_index;

   logic w_idle;
   logic w_fill;
   logic w_slide;
   logic w_done;
   logic w_write;
   logic w_last_write;
   logic w_advance;
   logic w_last_window;

   assign w_idle        = (r_state == S_IDLE);
   assign w_fill        = (r_state == S_FILL);
   assign w_slide       = (r_state == S_SLIDE);
   assign w_done        = (r_state == S_DONE);
   assign w_write       = w_fill && WrValid;
   assign w_last_write  = (r_write_reg == C_LAST_WR);
   assign w_advance     = w_slide && ReadEn;
   assign w_last_window = (r_base == C_LAST_BASE);

   // Phase sequencing: IDLE -> FILL -> SLIDE -> DONE -> IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (Start) r_state <= S_FILL;
            S_FILL:  if (w_write && w_last_write) r_state <= S_SLIDE;
            S_SLIDE: if (w_advance && w_last_window) r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Write address: steps on each accepted word, parks on the last address
   // through the slide phase, and returns to 0 when the sequence ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write_reg <= '0;
      end else if (w_idle && Start) begin
         r_write_reg <= '0;
      end else if (w_write && !w_last_write) begin
         r_write_reg <= r_write_reg + 1'b1;
      end else if (w_done) begin
         r_write_reg <= '0;
      end
   end

   // Window base and index: advance on ReadEn except on the last window,
   // where they hold through DONE and clear on the way back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base      <= '0;
         r_win_index <= '0;
      end else if (w_done) begin
         r_base      <= '0;
         r_win_index <= '0;
      end else if (w_advance && !w_last_window) begin
         r_base      <= r_base + C_STRIDE;
         r_win_index <= r_win_index + 1'b1;
      end
   end

   // One adder per tap; tap k always sits k words past the window base.
   genvar gi;
   generate
      for (gi = 0; gi < KSIZE; gi++) begin : g_tap
         assign ReadRegs[gi*ADDRESS +: ADDRESS] = r_base + ADDRESS'(gi);
      end
   endgenerate

   assign WriteEn   = w_write;
   assign WriteReg  = r_write_reg;
   assign ReadValid = w_slide;
   assign WinIndex  = r_win_index;
   assign Busy      = !w_idle;
   assign Done      = w_done;

endmodule

// File: tb/tb_window_address_counter.sv
// Bench for window_address_counter: three configurations share one stimulus
// stream; each is tracked by a phase/count model and compared every cycle.
module tb_window_address_counter;

   localparam int DN = 15;
   localparam int NC = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic wr_valid = 1'b0;
   logic read_en = 1'b0;

   logic [NC-1:0] we_o;
   logic [NC-1:0] rv_o;
   logic [NC-1:0] busy_o;
   logic [NC-1:0] done_o;
   logic [3:0]    wr_o  [NC];
   logic [3:0]    win_o [NC];
   logic [19:0]   rr_o  [NC];
   logic [11:0]   rr0;
   logic [11:0]   rr1;
   logic [19:0]   rr2;

   int checks = 0;
   int errors = 0;

   int ks [NC] = '{3, 3, 5};
   int st [NC] = '{1, 2, 3};

   // model: phase 0 idle, 1 fill, 2 slide, 3 done
   int m_ph  [NC];
   int m_cnt [NC];
   int m_win [NC];

   always #5 clk = ~clk;

   window_address_counter #(.ADDRESS(4), .DATANUM(DN), .KSIZE(3), .STRIDE(1)) u_c0 (
      .clk(clk), .rst_n(rst_n), .Start(start), .WrValid(wr_valid), .ReadEn(read_en),
      .WriteEn(we_o[0]), .WriteReg(wr_o[0]), .ReadRegs(rr0), .ReadValid(rv_o[0]),
      .WinIndex(win_o[0]), .Busy(busy_o[0]), .Done(done_o[0]));

   window_address_counter #(.ADDRESS(4), .DATANUM(DN), .KSIZE(3), .STRIDE(2)) u_c1 (
      .clk(clk), .rst_n(rst_n), .Start(start), .WrValid(wr_valid), .ReadEn(read_en),
      .WriteEn(we_o[1]), .WriteReg(wr_o[1]), .ReadRegs(rr1), .ReadValid(rv_o[1]),
      .WinIndex(win_o[1]), .Busy(busy_o[1]), .Done(done_o[1]));

   window_address_counter #(.ADDRESS(4), .DATANUM(DN), .KSIZE(5), .STRIDE(3)) u_c2 (
      .clk(clk), .rst_n(rst_n), .Start(start), .WrValid(wr_valid), .ReadEn(read_en),
      .WriteEn(we_o[2]), .WriteReg(wr_o[2]), .ReadRegs(rr2), .ReadValid(rv_o[2]),
      .WinIndex(win_o[2]), .Busy(busy_o[2]), .Done(done_o[2]));

   assign rr_o[0] = {8'd0, rr0};
   assign rr_o[1] = {8'd0, rr1};
   assign rr_o[2] = rr2;

   function automatic int nwin_of(int c);
      return (DN - ks[c]) / st[c] + 1;
   endfunction

   // Reference model: which phase, how many words written, which window.
   always @(posedge clk or negedge rst_n) begin
      for (int c = 0; c < NC; c++) begin
         if (!rst_n) begin
            m_ph[c]  <= 0;
            m_cnt[c] <= 0;
            m_win[c] <= 0;
         end else begin
            case (m_ph[c])
               0: if (start) begin m_ph[c] <= 1; m_cnt[c] <= 0; end
               1: if (wr_valid) begin
                     if (m_cnt[c] == DN - 1) begin m_ph[c] <= 2; m_win[c] <= 0; end
                     else m_cnt[c] <= m_cnt[c] + 1;
                  end
               2: if (read_en) begin
                     if (m_win[c] == nwin_of(c) - 1) m_ph[c] <= 3;
                     else m_win[c] <= m_win[c] + 1;
                  end
               default: begin m_ph[c] <= 0; m_cnt[c] <= 0; m_win[c] <= 0; end
            endcase
         end
      end
   end

   // Per-cycle comparison of every configuration against the model.
   always @(negedge clk) begin
      for (int c = 0; c < NC; c++) begin
         int e_wr, e_win, e_base;
         logic e_we, e_rv, e_busy, e_done, ok;
         logic [19:0] e_rr;
         e_wr   = 0;
         e_win  = 0;
         e_base = 0;
         e_we   = 1'b0;
         e_rv   = (m_ph[c] == 2);
         e_busy = (m_ph[c] != 0);
         e_done = (m_ph[c] == 3);
         case (m_ph[c])
            1: begin e_wr = m_cnt[c]; e_we = wr_valid; end
            2: begin e_wr = DN - 1; e_win = m_win[c]; e_base = m_win[c] * st[c]; end
            3: begin e_win = nwin_of(c) - 1; e_base = e_win * st[c]; end
            default: ;
         endcase
         e_rr = '0;
         for (int k = 0; k < ks[c]; k++) e_rr[k*4 +: 4] = 4'(e_base + k);
         ok = (we_o[c] == e_we) && (rv_o[c] == e_rv) && (busy_o[c] == e_busy) &&
              (done_o[c] == e_done) && (win_o[c] == 4'(e_win)) && (rr_o[c] == e_rr) &&
              (m_ph[c] == 3 || wr_o[c] == 4'(e_wr));
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL cycle_cfg%0d t=%0t got we=%0b wr=%0d rr=%h rv=%0b win=%0d busy=%0b done=%0b required we=%0b wr=%0d rr=%h rv=%0b win=%0d busy=%0b done=%0b",
                     c, $time, we_o[c], wr_o[c], rr_o[c], rv_o[c], win_o[c], busy_o[c], done_o[c],
                     e_we, e_wr, e_rr, e_rv, e_win, e_busy, e_done);
         end
      end
      // Tail word 14 must never reach a tap when KSIZE=5, STRIDE=3.
      if (rv_o[2]) begin
         logic hit;
         hit = 1'b0;
         for (int k = 0; k < 5; k++) if (rr_o[2][k*4 +: 4] == 4'd14) hit = 1'b1;
         checks++;
         if (hit) begin
            errors++;
            $display("FAIL tail_tap cfg2 got taps=%h required no tap equal to 14", rr_o[2]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0h required %0h", name, got, want);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_taps", int'(rr0), 'h210);
      chk("reset_busy", int'(busy_o[0]), 0);

      // Full default sequence with continuous handshakes.
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wr_valid = 1'b1;
      @(negedge clk);
      chk("fill_first_wr", int'(wr_o[0]), 0);
      chk("fill_first_we", int'(we_o[0]), 1);
      repeat (15) tick();
      wr_valid = 1'b0;
      read_en = 1'b1;
      @(negedge clk);
      chk("first_window", int'(rr0), 'h210);
      chk("first_valid", int'(rv_o[0]), 1);
      for (int i = 1; i <= 13; i++) begin
         if (i == 13) begin
            tick();
            start = 1'b1;
            read_en = 1'b0;
         end else begin
            tick();
         end
         @(negedge clk);
         if (i == 6) chk("cfg1_last_window", int'(rr1), 'hEDC);
         if (i == 7) chk("cfg1_done", int'(done_o[1]), 1);
         if (i == 3) chk("cfg2_last_window", int'(rr2), 'hDCBA9);
         if (i == 4) chk("cfg2_done", int'(done_o[2]), 1);
         if (i == 12) chk("cfg0_last_window", int'(rr0), 'hEDC);
      end
      chk("cfg0_done", int'(done_o[0]), 1);
      chk("cfg0_done_rv", int'(rv_o[0]), 0);
      tick();
      @(negedge clk);
      chk("start_in_done_ignored", int'(busy_o[0]), 0);
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("restart_busy", int'(busy_o[0]), 1);
      chk("restart_wr", int'(wr_o[0]), 0);

      // Reach base 6 in SLIDE, then reset asynchronously mid-cycle.
      wr_valid = 1'b1;
      repeat (15) tick();
      wr_valid = 1'b0;
      read_en = 1'b1;
      repeat (6) tick();
      read_en = 1'b0;
      chk("pre_reset_taps", int'(rr0), 'h876);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_taps", int'(rr0), 'h210);
      chk("async_reset_rv", int'(rv_o[0]), 0);
      chk("async_reset_win", int'(win_o[0]), 0);
      chk("async_reset_busy", int'(busy_o[0]), 0);
      tick();
      rst_n = 1'b1;
      read_en = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("readen_ignored_idle", int'(rv_o[0]), 0);
      read_en = 1'b0;

      // Randomized handshakes with gaps and stray Start pulses.
      for (int n = 0; n < 3000; n++) begin
         tick();
         start    = ($urandom % 8) == 0;
         wr_valid = ($urandom % 4) != 0;
         read_en  = ($urandom % 3) != 0;
      end
      tick();
      start = 1'b0;
      wr_valid = 1'b0;
      read_en = 1'b0;
      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
